// File: rtl/alu_exec_unit.sv
// Handshaked 16-bit ALU execute stage: single-cycle ADD/SUB/AND/OR/SLT and an
// iterative shift-add unsigned MUL. Results are returned over a valid/ready channel.
module alu_exec_unit #(
  parameter int WIDTH     = 16,
  parameter int MUL_STEPS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             overflow,
  output logic             illegal
);

  localparam int CNT_W = $clog2(MUL_STEPS + 1);

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_SLT = 3'd4;
  localparam logic [2:0] OP_MUL = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_mul_last;

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_mplier_next;

  logic [WIDTH-1:0] w_add;
  logic [WIDTH-1:0] w_sub;
  logic             w_lt;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_ovf;
  logic             w_alu_ill;

  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] r_result_hi;
  logic             r_zero;
  logic             r_overflow;
  logic             r_illegal;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_next = (alu_control == OP_MUL) ? S_BUSY : S_DONE;
      end
      S_BUSY: begin
        if (w_mul_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_accept   = (r_state == S_IDLE) && in_valid;
  assign w_mul_last = (r_count == CNT_W'(MUL_STEPS - 1));

  assign w_add = op_a + op_b;
  assign w_sub = op_a - op_b;
  assign w_lt  = $signed(op_a) < $signed(op_b);

  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    w_alu_ill = 1'b0;
    case (alu_control)
      OP_ADD: begin
        w_alu_res = w_add;
        w_alu_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (w_add[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_alu_res = w_sub;
        w_alu_ovf = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (w_sub[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_AND:  w_alu_res = op_a & op_b;
      OP_OR:   w_alu_res = op_a | op_b;
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, w_lt};
      OP_MUL:  w_alu_res = '0;
      default: w_alu_ill = 1'b1;
    endcase
  end

  // One shift-add step: conditionally add the multiplicand into the upper half,
  // then shift the {acc, multiplier} pair right with the carry entering at the top.
  assign w_sum         = {1'b0, r_acc} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
  assign w_acc_next    = w_sum[WIDTH:1];
  assign w_mplier_next = {w_sum[0], r_mplier[WIDTH-1:1]};

  // NOTE: the multiply working registers are always loaded at accept before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_mcand  <= op_a;
      r_mplier <= op_b;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (r_state == S_BUSY) begin
      r_acc    <= w_acc_next;
      r_mplier <= w_mplier_next;
      r_count  <= r_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result    <= '0;
      r_result_hi <= '0;
      r_zero      <= 1'b0;
      r_overflow  <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (w_accept) begin
      r_illegal <= w_alu_ill;
      if (alu_control != OP_MUL) begin
        r_result    <= w_alu_res;
        r_result_hi <= '0;
        r_zero      <= (w_alu_res == '0);
        r_overflow  <= w_alu_ovf;
      end
    end else if ((r_state == S_BUSY) && w_mul_last) begin
      r_result    <= w_mplier_next;
      r_result_hi <= w_acc_next;
      r_zero      <= (w_mplier_next == '0);
      r_overflow  <= 1'b0;
    end
  end

  assign result    = r_result;
  assign result_hi = r_result_hi;
  assign zero      = r_zero;
  assign overflow  = r_overflow;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alu_control;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [15:0] result_hi;
  logic        zero;
  logic        overflow;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [15:0] res;
    logic [15:0] hi;
    logic        z;
    logic        ov;
    logic        il;
  } out_t;

  always #5 clk = ~clk;

  alu_exec_unit dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .alu_control(alu_control),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .result_hi  (result_hi),
    .zero       (zero),
    .overflow   (overflow),
    .illegal    (illegal)
  );

  // Reference: plain integer arithmetic on sign-extended / zero-extended operands.
  function automatic out_t model(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b);
    int    sa;
    int    sb;
    int    s;
    longint p;
    out_t  e;
    sa = int'($signed(a));
    sb = int'($signed(b));
    e  = '0;
    case (c)
      3'd0: begin s = sa + sb; e.res = s[15:0]; e.ov = (s > 32767) || (s < -32768); end
      3'd1: begin s = sa - sb; e.res = s[15:0]; e.ov = (s > 32767) || (s < -32768); end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = (sa < sb) ? 16'd1 : 16'd0;
      3'd5: begin p = longint'(a) * longint'(b); e.res = p[15:0]; e.hi = p[31:16]; end
      default: e.il = 1'b1;
    endcase
    e.z = (e.res == 16'd0);
    return e;
  endfunction

  function automatic out_t sample();
    return {result, result_hi, zero, overflow, illegal};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Issue one request from IDLE, scramble inputs after accept, measure latency,
  // optionally stall, then complete the output handshake. Returns in IDLE.
  task automatic do_op(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b,
                       input int stall, output out_t obs, output int lat);
    @(negedge clk);
    in_valid = 1'b1; alu_control = c; op_a = a; op_b = b;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; alu_control = 3'($urandom); op_a = 16'($urandom); op_b = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    repeat (stall) @(negedge clk);
    obs = sample();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_control = 3'd0; op_a = 16'd0; op_b = 16'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++;
    if ({in_ready, out_valid, sample()} !== {1'b1, 1'b0, 35'd0}) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b vld=%b out=%h exp rdy=1 vld=0 out=0", in_ready, out_valid, sample());
    end
    @(negedge clk);
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL reset_idle: got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_add_sub;
    logic [2:0]  cs [6] = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd1};
    logic [15:0] as [6] = '{16'h7FFF, 16'h0005, 16'h8000, 16'hFFFF, 16'h8000, 16'h7FFF};
    logic [15:0] bs [6] = '{16'h0001, 16'h0005, 16'h0001, 16'h0001, 16'h8000, 16'hFFFF};
    out_t exp, obs;
    int   lat;
    for (int i = 0; i < 6; i++) begin
      exp = model(cs[i], as[i], bs[i]);
      do_op(cs[i], as[i], bs[i], 0, obs, lat);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL add_sub[%0d]: got %h exp %h", i, obs, exp);
      end
      total++;
      if (lat !== 1) begin
        bad++;
        $display("FAIL add_sub_lat[%0d]: got %0d exp 1", i, lat);
      end
    end
  endtask

  task automatic test_slt;
    logic [15:0] as [4] = '{16'hFFFF, 16'h0001, 16'h8000, 16'h1234};
    logic [15:0] bs [4] = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h1234};
    out_t exp, obs;
    int   lat;
    for (int i = 0; i < 4; i++) begin
      exp = model(3'd4, as[i], bs[i]);
      do_op(3'd4, as[i], bs[i], 0, obs, lat);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL slt[%0d]: got %h exp %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_mul;
    logic [15:0] as [5] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h0001, 16'h8000};
    logic [15:0] bs [5] = '{16'h0100, 16'hFFFF, 16'hBEEF, 16'hFFFF, 16'h0002};
    logic [15:0] a, b;
    out_t exp, obs;
    int   lat;
    for (int i = 0; i < 9; i++) begin
      a = (i < 5) ? as[i] : 16'($urandom);
      b = (i < 5) ? bs[i] : 16'($urandom);
      exp = model(3'd5, a, b);
      do_op(3'd5, a, b, i % 3, obs, lat);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL mul[%0d] %h*%h: got %h exp %h", i, a, b, obs, exp);
      end
      total++;
      if (lat !== 17) begin
        bad++;
        $display("FAIL mul_lat[%0d]: got %0d exp 17", i, lat);
      end
    end
  endtask

  task automatic test_stall;
    out_t exp, snap;
    int   lat;
    exp = model(3'd0, 16'h1234, 16'h1111);
    @(negedge clk);
    in_valid = 1'b1; alu_control = 3'd0; op_a = 16'h1234; op_b = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    alu_control = 3'd1; op_a = 16'hFFFF; op_b = 16'h0001;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    snap = sample();
    total++;
    if (snap !== exp || lat !== 1) begin
      bad++;
      $display("FAIL stall_first: got %h lat=%0d exp %h lat=1", snap, lat, exp);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({out_valid, in_ready, sample()} !== {1'b1, 1'b0, exp}) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got vld=%b rdy=%b out=%h exp vld=1 rdy=0 out=%h",
                 i, out_valid, in_ready, sample(), exp);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin
      bad++;
      $display("FAIL stall_release: got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_illegal;
    out_t exp, obs;
    int   lat;
    exp = model(3'd7, 16'hAAAA, 16'h5555);
    do_op(3'd7, 16'hAAAA, 16'h5555, 0, obs, lat);
    total++;
    if (obs !== exp || lat !== 1) begin
      bad++;
      $display("FAIL illegal7: got %h lat=%0d exp %h lat=1", obs, lat, exp);
    end
    total++;
    if (illegal !== 1'b1) begin
      bad++;
      $display("FAIL illegal_sticky_idle: got %b exp 1", illegal);
    end
    exp = model(3'd2, 16'hF0F0, 16'h0FF0);
    do_op(3'd2, 16'hF0F0, 16'h0FF0, 0, obs, lat);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL illegal_then_and: got %h exp %h", obs, exp);
    end
    do_op(3'd6, 16'h1111, 16'h2222, 0, obs, lat);
    exp = model(3'd6, 16'h1111, 16'h2222);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL illegal6: got %h exp %h", obs, exp);
    end
    exp = model(3'd5, 16'h0003, 16'h0005);
    do_op(3'd5, 16'h0003, 16'h0005, 0, obs, lat);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL illegal_then_mul: got %h exp %h", obs, exp);
    end
  endtask

  task automatic test_reset_mid_mul;
    out_t obs, exp;
    int   lat;
    logic seen;
    @(negedge clk);
    in_valid = 1'b1; alu_control = 3'd5; op_a = 16'h1234; op_b = 16'hFFFF;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({in_ready, out_valid, sample()} !== {1'b1, 1'b0, 35'd0}) begin
      bad++;
      $display("FAIL mid_mul_reset: got rdy=%b vld=%b out=%h exp rdy=1 vld=0 out=0", in_ready, out_valid, sample());
    end
    seen = 1'b0;
    out_ready = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL mid_mul_no_output: got out_valid seen=%b exp 0", seen);
    end
    exp = model(3'd0, 16'd2, 16'd3);
    do_op(3'd0, 16'd2, 16'd3, 0, obs, lat);
    total++;
    if (obs !== exp || obs.res !== 16'd5) begin
      bad++;
      $display("FAIL mid_mul_then_add: got %h exp %h", obs, exp);
    end
  endtask

  task automatic test_random;
    logic [2:0]  c;
    logic [15:0] a, b;
    out_t exp, obs;
    int   lat;
    int   stall;
    for (int i = 0; i < 60; i++) begin
      c = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      stall = $urandom_range(0, 3);
      exp = model(c, a, b);
      do_op(c, a, b, stall, obs, lat);
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL random[%0d] op=%0d %h,%h: got %h exp %h", i, c, a, b, obs, exp);
      end
      total++;
      if (lat !== ((c == 3'd5) ? 17 : 1)) begin
        bad++;
        $display("FAIL random_lat[%0d] op=%0d: got %0d exp %0d", i, c, lat, (c == 3'd5) ? 17 : 1);
      end
    end
  endtask

  initial begin
    test_reset;
    test_add_sub;
    test_slt;
    test_mul;
    test_stall;
    test_illegal;
    test_reset_mid_mul;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
